// File: rtl/miner_pkg.sv
// Shared definitions for the nonce generator, dispatcher and hash core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package miner_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESTART   = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } dispatch_state_t;

endpackage

// File: rtl/inflight_tracker.sv
// Up/down credit counter of nonces handed to the hash core with no result back yet.
// Latency: count updates on the edge after inc/dec; empty_o looks ahead to that update.
// Backpressure: has_credit_o low once MAX_INFLIGHT are outstanding; extra decrements at 0 are dropped.
module inflight_tracker #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic has_credit_o,
    output logic empty_o
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, simultaneous inc/dec cancel, a decrement at zero is a stray result and is ignored.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign has_credit_o = (count_q < CNT_MAX);
    // Empty as of the end of this cycle, so a final returning result counts as drained immediately.
    assign empty_o      = (count_d == '0);

endmodule

// File: rtl/nonce_dispatcher.sv
// Feeds successive generator nonces to the hash core for one job and latches the first hit.
// Latency: start -> restart pulse next cycle -> first nonce offered the cycle after; one nonce per cycle thereafter.
// Backpressure: holds hash_nonce while hash_ready is low; stalls when MAX_INFLIGHT results are outstanding.
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] gen_nonce,
    input  logic               gen_overflow,
    output logic               gen_enable,
    output logic               gen_restart,
    output logic               hash_valid,
    output logic [NONCE_W-1:0] hash_nonce,
    input  logic               hash_ready,
    input  logic               result_valid,
    input  logic               result_hit,
    input  logic [NONCE_W-1:0] result_nonce,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce
);

    dispatch_state_t    state_q, state_d;
    logic               hit_q, hit_d;
    logic               abort_q, abort_d;
    logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;

    logic has_credit;
    logic cnt_empty;
    logic idle_like;
    logic clear_cnt;
    logic hit_fire;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_FOUND) || (state_q == ST_EXHAUSTED);
    assign clear_cnt = start && idle_like;
    // Only the first hit of an active job counts; stray results outside a job are ignored.
    assign hit_fire  = result_valid && result_hit && !hit_q &&
                       ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    assign hash_valid  = (state_q == ST_ISSUE) && has_credit && !gen_overflow;
    assign hash_nonce  = gen_nonce;
    assign gen_enable  = hash_valid && hash_ready;
    assign gen_restart = (state_q == ST_RESTART);
    assign busy        = (state_q == ST_RESTART) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign found       = (state_q == ST_FOUND);
    assign exhausted   = (state_q == ST_EXHAUSTED);
    assign found_nonce = found_nonce_q;

    inflight_tracker #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_tracker (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear_i      (clear_cnt),
        .inc_i        (gen_enable),
        .dec_i        (result_valid),
        .has_credit_o (has_credit),
        .empty_o      (cnt_empty)
    );

    // Next state, hit latch and abort flag; DRAIN exit priority is abort, then hit, then exhaustion.
    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        abort_d       = abort_q;
        found_nonce_d = found_nonce_q;
        if (hit_fire) begin
            found_nonce_d = result_nonce;
            hit_d         = 1'b1;
        end
        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (start) begin
                    state_d = ST_RESTART;
                    hit_d   = 1'b0;
                    abort_d = 1'b0;
                end
            end
            ST_RESTART: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end else if (hit_fire || gen_overflow) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (cnt_empty) begin
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else if (hit_d) begin
                        state_d = ST_FOUND;
                    end else begin
                        state_d = ST_EXHAUSTED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and job-status registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            hit_q         <= 1'b0;
            abort_q       <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            hit_q         <= hit_d;
            abort_q       <= abort_d;
            found_nonce_q <= found_nonce_d;
        end
    end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: table of jobs run against behavioural generator and hash-core models.
// Two instances (MAX_INFLIGHT 4 and 1) share stimulus; sel picks which one is active.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_nonce_dispatcher;
    import miner_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               n_rst, start, abort, hash_ready, result_valid, result_hit, gen_overflow, sel;
    logic [NONCE_W-1:0] result_nonce, gen_nonce;

    logic               ge_a, gr_a, hv_a, busy_a, found_a, exh_a;
    logic               ge_b, gr_b, hv_b, busy_b, found_b, exh_b;
    logic [NONCE_W-1:0] hn_a, fn_a, hn_b, fn_b;
    logic               ge, gr, hv, busy, found, exh;
    logic [NONCE_W-1:0] hn, fn;

    nonce_dispatcher #(.MAX_INFLIGHT(4)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .start(start && !sel), .abort(abort && !sel),
        .gen_nonce(gen_nonce), .gen_overflow(gen_overflow), .gen_enable(ge_a), .gen_restart(gr_a),
        .hash_valid(hv_a), .hash_nonce(hn_a), .hash_ready(hash_ready && !sel),
        .result_valid(result_valid && !sel), .result_hit(result_hit), .result_nonce(result_nonce),
        .busy(busy_a), .found(found_a), .exhausted(exh_a), .found_nonce(fn_a)
    );

    nonce_dispatcher #(.MAX_INFLIGHT(1)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .start(start && sel), .abort(abort && sel),
        .gen_nonce(gen_nonce), .gen_overflow(gen_overflow), .gen_enable(ge_b), .gen_restart(gr_b),
        .hash_valid(hv_b), .hash_nonce(hn_b), .hash_ready(hash_ready && sel),
        .result_valid(result_valid && sel), .result_hit(result_hit), .result_nonce(result_nonce),
        .busy(busy_b), .found(found_b), .exhausted(exh_b), .found_nonce(fn_b)
    );

    assign ge    = sel ? ge_b    : ge_a;
    assign gr    = sel ? gr_b    : gr_a;
    assign hv    = sel ? hv_b    : hv_a;
    assign hn    = sel ? hn_b    : hn_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign found = sel ? found_b : found_a;
    assign exh   = sel ? exh_b   : exh_a;
    assign fn    = sel ? fn_b    : fn_a;

    typedef struct {
        logic [NONCE_W-1:0] n;
        int                 due;
    } pend_t;

    typedef struct {
        bit                 sel;
        int                 lat_min;
        int                 lat_max;
        bit                 rand_ready;
        bit                 hit_en;
        logic [NONCE_W-1:0] hit_thr;
        bit                 pre_en;
        logic [NONCE_W-1:0] pre_val;
        int                 abort_at;
        bit                 exp_found;
        bit                 exp_exh;
        logic [NONCE_W-1:0] exp_fn;
        int                 exp_issued;
    } vec_t;

    vec_t  vecs[6];
    pend_t pq[$];

    // Behavioural models: generator counter, hash core queue, job bookkeeping.
    logic [NONCE_W-1:0] gen_m, pre_val, hit_thr, exp_next;
    logic               ovf_m;
    bit                 pre_en, hit_en, no_issue, hit_seen, job_active;
    int                 lat_min, lat_max, cyc, issued, out_m, max_cur;
    int                 checks, failures;

    logic               o_hv, o_gr, o_busy, o_found, o_exh;
    logic [NONCE_W-1:0] o_hn, o_fn;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: observe and check, advance models across the rising edge, drive next inputs.
    task automatic tick();
        bit    hs;
        int    due;
        pend_t p;
        #1;
        o_hv = hv; o_hn = hn; o_gr = gr; o_busy = busy; o_found = found; o_exh = exh; o_fn = fn;
        hs = hv && hash_ready;
        chk1("gen_enable", ge, hs);
        chk32("hash_nonce_passthru", hn, gen_nonce);
        if (no_issue || gen_overflow || !job_active) chk1("no_issue", hv, 1'b0);
        if (hv) chk32("offered_nonce", hn, exp_next);
        if (result_valid && out_m > 0) out_m--;
        if (result_valid && result_hit && job_active && !hit_seen) begin
            hit_seen = 1'b1;
            no_issue = 1'b1;
        end
        if (abort && busy) no_issue = 1'b1;
        if (hs) begin
            exp_next = hn + 1;
            issued++;
            out_m++;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (pq.size() > 0 && due < pq[$].due) due = pq[$].due;
            p.n = hn;
            p.due = due;
            pq.push_back(p);
        end
        chk1("inflight_bound", out_m <= max_cur, 1'b1);
        if (gr) begin
            gen_m = pre_en ? pre_val : '0;
            ovf_m = 1'b0;
        end else if (ge) begin
            if (gen_m == 32'hFFFF_FFFF) ovf_m = 1'b1;
            gen_m = gen_m + 1;
        end
        cyc++;
        @(negedge clk);
        gen_nonce    = gen_m;
        gen_overflow = ovf_m;
        start        = 1'b0;
        abort        = 1'b0;
        result_valid = 1'b0;
        result_hit   = 1'b0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            result_valid = 1'b1;
            result_nonce = p.n;
            result_hit   = hit_en && (p.n >= hit_thr);
        end
    endtask

    task automatic run_job(input vec_t v);
        bit                 done;
        logic [NONCE_W-1:0] first;
        sel      = v.sel;
        max_cur  = v.sel ? 1 : 4;
        lat_min  = v.lat_min;
        lat_max  = v.lat_max;
        hit_en   = v.hit_en;
        hit_thr  = v.hit_thr;
        pre_en   = v.pre_en;
        pre_val  = v.pre_val;
        first    = v.pre_en ? v.pre_val : '0;
        exp_next = first;
        issued   = 0;
        hit_seen = 1'b0;
        no_issue = 1'b0;
        job_active = 1'b1;
        start = 1'b1;
        hash_ready = 1'b1;
        tick();
        tick();
        chk1("restart_pulse", o_gr, 1'b1);
        chk1("busy_in_restart", o_busy, 1'b1);
        chk1("no_valid_in_restart", o_hv, 1'b0);
        hash_ready = v.rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        tick();
        chk1("restart_single_cycle", o_gr, 1'b0);
        chk1("first_valid", o_hv, 1'b1);
        chk32("first_nonce", o_hn, first);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            hash_ready = v.rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (v.abort_at >= 0 && issued == v.abort_at && !no_issue) begin
                abort = 1'b1;
                hash_ready = 1'b0;
            end
            tick();
            if (o_found || o_exh || (v.abort_at >= 0 && !o_busy)) done = 1'b1;
        end
        chk1("job_completes", done, 1'b1);
        chk1("found", o_found, v.exp_found);
        chk1("exhausted", o_exh, v.exp_exh);
        chk1("busy_at_end", o_busy, 1'b0);
        chk32("found_nonce", o_fn, v.exp_fn);
        if (v.exp_issued >= 0) chk32("issued_count", issued, v.exp_issued);
        chk32("outstanding_at_end", out_m, 0);
        job_active = 1'b0;
        hash_ready = 1'b0;
        tick();
        chk1("status_holds", o_found || o_exh, v.exp_found || v.exp_exh);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; hash_ready = 1'b0; sel = 1'b0;
        result_valid = 1'b0; result_hit = 1'b0; result_nonce = '0;
        gen_nonce = '0; gen_overflow = 1'b0; gen_m = '0; ovf_m = 1'b0;
        pre_en = 1'b0; pre_val = '0; hit_en = 1'b0; hit_thr = '0; exp_next = '0;
        no_issue = 1'b0; hit_seen = 1'b0; job_active = 1'b0;
        lat_min = 3; lat_max = 3; cyc = 0; issued = 0; out_m = 0; max_cur = 4;

        //          sel   lmin lmax rrdy  hit   thr           pre   preval        abrt  fnd   exh   fn        issued
        vecs[0] = '{1'b0, 3,   3,   1'b0, 1'b1, 32'd57,       1'b0, 32'd0,        -1,   1'b1, 1'b0, 32'd57,   61};
        vecs[1] = '{1'b0, 3,   3,   1'b0, 1'b0, 32'd0,        1'b1, 32'hFFFFFFFE, -1,   1'b0, 1'b1, 32'd57,   2};
        vecs[2] = '{1'b1, 1,   4,   1'b1, 1'b1, 32'd20,       1'b0, 32'd0,        -1,   1'b1, 1'b0, 32'd20,   21};
        vecs[3] = '{1'b0, 1,   5,   1'b1, 1'b1, 32'd30,       1'b0, 32'd0,        -1,   1'b1, 1'b0, 32'd30,   -1};
        vecs[4] = '{1'b0, 3,   3,   1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        2,    1'b0, 1'b0, 32'd30,   2};
        vecs[5] = '{1'b0, 2,   2,   1'b0, 1'b1, 32'd5,        1'b0, 32'd0,        -1,   1'b1, 1'b0, 32'd5,    8};

        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk1("rst_hash_valid", hv, 1'b0);
            chk1("rst_gen_enable", ge, 1'b0);
            chk1("rst_gen_restart", gr, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_found", found, 1'b0);
            chk1("rst_exhausted", exh, 1'b0);
            chk32("rst_found_nonce", fn, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                // Stray hit result while idle must not disturb status or the credit counter.
                result_valid = 1'b1;
                result_hit   = 1'b1;
                result_nonce = 32'h0000_1234;
                tick();
                tick();
                chk1("stray_found", o_found, 1'b0);
                chk1("stray_busy", o_busy, 1'b0);
                chk32("stray_found_nonce", o_fn, 32'd30);
            end
            run_job(vecs[i]);
        end

        // Reset in the middle of a job: everything returns to reset values, in-flight results dropped.
        sel = 1'b0; lat_min = 3; lat_max = 3; hit_en = 1'b0; pre_en = 1'b0;
        max_cur = 4; exp_next = '0; no_issue = 1'b0; job_active = 1'b1;
        start = 1'b1; hash_ready = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            hash_ready = 1'b1;
            tick();
        end
        n_rst = 1'b0;
        #1;
        chk1("midrst_hash_valid", hv, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_found", found, 1'b0);
        chk32("midrst_found_nonce", fn, 32'd0);
        pq.delete();
        gen_m = '0; ovf_m = 1'b0; out_m = 0; job_active = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            hash_ready = 1'b1;
            tick();
            chk1("post_rst_idle", o_busy || o_found || o_exh, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
